// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: FSM states, instruction
// field positions and the opcode map driven to the control unit.
package fetch_decode_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DECODE  = 2'd2,
      ST_EXECUTE = 2'd3
   } state_e;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 12;
   localparam int IMMED_BIT = 11;
   localparam int RD_MSB    = 10;
   localparam int RD_LSB    = 8;
   localparam int RS_MSB    = 7;
   localparam int RS_LSB    = 5;
   localparam int IMM8_MSB  = 7;
   localparam int IMM8_LSB  = 0;

   typedef enum logic [3:0] {
      OP_JMP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_LSL = 4'h3,
      OP_LSR = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
      OP_LD  = 4'h8, OP_ST  = 4'h9, OP_MOV = 4'hA, OP_BE  = 4'hB,
      OP_BNE = 4'hC, OP_BLT = 4'hD, OP_BGT = 4'hE, OP_CMP = 4'hF
   } opcode_e;

endpackage

// File: rtl/fetch_decode_stage_pc.sv
// Program counter: synchronous reset, sequential step, branch load.
// A load always wins over the increment.
module program_counter
   import fetch_decode_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        inc_i,
   input  logic        load_i,
   input  logic [15:0] target_i,
   output logic [15:0] pc_o
);

   logic [15:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i)
         pc_d = target_i;
      else if (inc_i)
         pc_d = pc_q + PC_STEP;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) pc_q <= RESET_PC;
      else         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: IDLE -> FETCH -> DECODE -> EXECUTE sequencer holding the
// instruction register and presenting decoded fields to the control unit.
module fetch_decode_stage
   import fetch_decode_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        en_i,
   output logic        mem_req_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [15:0] mem_rdata_i,
   input  logic        exec_done_i,
   input  logic        pc_load_i,
   input  logic [15:0] pc_target_i,
   output logic [3:0]  op_o,
   output logic        immed_o,
   output logic [2:0]  rd_o,
   output logic [2:0]  rs_o,
   output logic [7:0]  imm8_o,
   output logic        instr_valid_o,
   output logic [15:0] pc_out_o,
   output logic        fetch_o,
   output logic        decode_o,
   output logic        execute_o
);

   state_e      state_q;
   logic [15:0] ir_q, pc_out_q, pc;
   logic        fetch_q, decode_q, execute_q, valid_q;
   logic        accept, branch;

   // An ack only counts while the request is actually being driven.
   assign mem_req_o = fetch_q & en_i;
   assign accept    = (state_q == ST_FETCH) & en_i & mem_ack_i;
   assign branch    = (state_q == ST_EXECUTE) & exec_done_i & pc_load_i;

   program_counter #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .inc_i    (accept),
      .load_i   (branch),
      .target_i (pc_target_i),
      .pc_o     (pc)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         ir_q      <= 16'h0000;
         pc_out_q  <= RESET_PC;
         fetch_q   <= 1'b0;
         decode_q  <= 1'b0;
         execute_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
               fetch_q <= 1'b1;
            end
            ST_FETCH: begin
               if (accept) begin
                  ir_q     <= mem_rdata_i;
                  pc_out_q <= pc;
                  state_q  <= ST_DECODE;
                  fetch_q  <= 1'b0;
                  decode_q <= 1'b1;
                  valid_q  <= 1'b1;
               end
            end
            ST_DECODE: begin
               state_q   <= ST_EXECUTE;
               decode_q  <= 1'b0;
               execute_q <= 1'b1;
               valid_q   <= 1'b0;
            end
            default: begin
               if (exec_done_i) begin
                  state_q   <= ST_FETCH;
                  execute_q <= 1'b0;
                  fetch_q   <= 1'b1;
               end
            end
         endcase
      end
   end

   assign mem_addr_o    = pc;
   assign op_o          = ir_q[OP_MSB:OP_LSB];
   assign immed_o       = ir_q[IMMED_BIT];
   assign rd_o          = ir_q[RD_MSB:RD_LSB];
   assign rs_o          = ir_q[RS_MSB:RS_LSB];
   assign imm8_o        = ir_q[IMM8_MSB:IMM8_LSB];
   assign instr_valid_o = valid_q;
   assign pc_out_o      = pc_out_q;
   assign fetch_o       = fetch_q;
   assign decode_o      = decode_q;
   assign execute_o     = execute_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench: a phase-level model predicts every accepted fetch, a
// monitor checks each instr_valid pulse; a second instance starts at FFFF.
module tb_fetch_decode_stage;

   localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1, en = 1'b0, mem_ack = 1'b0, exec_done = 1'b0, pc_load = 1'b0;
   logic [15:0] mem_rdata = '0, pc_target = '0;

   logic        mem_req, instr_valid, immed, fetch, decode, execute;
   logic [15:0] mem_addr, pc_out;
   logic [3:0]  op;
   logic [2:0]  rd, rs;
   logic [7:0]  imm8;

   logic        w_mem_req, w_instr_valid, w_immed, w_fetch, w_decode, w_execute;
   logic [15:0] w_mem_addr, w_pc_out;
   logic [3:0]  w_op;
   logic [2:0]  w_rd, w_rs;
   logic [7:0]  w_imm8;

   fetch_decode_stage #(.RESET_PC(16'h0000), .PC_STEP(16'd1)) dut (
      .clk_i(clk), .reset_i(reset), .en_i(en), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .exec_done_i(exec_done),
      .pc_load_i(pc_load), .pc_target_i(pc_target), .op_o(op), .immed_o(immed),
      .rd_o(rd), .rs_o(rs), .imm8_o(imm8), .instr_valid_o(instr_valid),
      .pc_out_o(pc_out), .fetch_o(fetch), .decode_o(decode), .execute_o(execute));

   fetch_decode_stage #(.RESET_PC(16'hFFFF), .PC_STEP(16'd1)) dut_w (
      .clk_i(clk), .reset_i(reset), .en_i(en), .mem_req_o(w_mem_req), .mem_addr_o(w_mem_addr),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .exec_done_i(exec_done),
      .pc_load_i(pc_load), .pc_target_i(pc_target), .op_o(w_op), .immed_o(w_immed),
      .rd_o(w_rd), .rs_o(w_rs), .imm8_o(w_imm8), .instr_valid_o(w_instr_valid),
      .pc_out_o(w_pc_out), .fetch_o(w_fetch), .decode_o(w_decode), .execute_o(w_execute));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [15:0] pc;
      logic [15:0] pcw;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0, n_pass = 0;
   int   ph = P_IDLE;
   logic [15:0] m_pc = 16'h0000, m_pcw = 16'hFFFF;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One cycle: drive inputs, check the cycle's visible state, advance the model.
   task automatic apply(input bit r, input bit e, input bit a, input logic [15:0] d,
                        input bit dn, input bit ld, input logic [15:0] t);
      exp_t x;
      @(negedge clk);
      reset = r; en = e; mem_ack = a; mem_rdata = d;
      exec_done = dn; pc_load = ld; pc_target = t;
      #1;
      chk("mem_req", 32'(mem_req), 32'((ph == P_FETCH) && e));
      chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("w_mem_addr", 32'(w_mem_addr), 32'(m_pcw));
      chk("instr_valid", 32'(instr_valid), 32'(ph == P_DEC));
      chk("phase", 32'({fetch, decode, execute}),
          32'({ph == P_FETCH, ph == P_DEC, ph == P_EXEC}));
      if (ph == P_IDLE) begin
         chk("ir_after_reset", 32'({op, immed, rd, rs, imm8}), 32'(0));
         chk("pc_out_reset", 32'(pc_out), 32'(16'h0000));
         chk("w_pc_out_reset", 32'(w_pc_out), 32'(16'hFFFF));
      end
      if (r) begin
         ph = P_IDLE; m_pc = 16'h0000; m_pcw = 16'hFFFF;
      end else begin
         case (ph)
            P_IDLE:  ph = P_FETCH;
            P_FETCH: if (e && a) begin
               x.d = d; x.pc = m_pc; x.pcw = m_pcw;
               sb.push_back(x);
               m_pc = m_pc + 16'd1; m_pcw = m_pcw + 16'd1;
               ph = P_DEC;
            end
            P_DEC:   ph = P_EXEC;
            default: if (dn) begin
               if (ld) begin m_pc = t; m_pcw = t; end
               ph = P_FETCH;
            end
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (instr_valid) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_instr_valid: got pulse expected none at %0t", $time);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("op", 32'(op), 32'(x.d[15:12]));
            chk("immed", 32'(immed), 32'(x.d[11]));
            chk("rd", 32'(rd), 32'(x.d[10:8]));
            chk("rs", 32'(rs), 32'(x.d[7:5]));
            chk("imm8", 32'(imm8), 32'(x.d[7:0]));
            chk("pc_out", 32'(pc_out), 32'(x.pc));
            chk("w_pc_out", 32'(w_pc_out), 32'(x.pcw));
            chk("w_ir", 32'({w_op, w_immed, w_rd, w_imm8}), 32'({x.d[15:11], x.d[10:8], x.d[7:0]}));
         end
      end
   end

   initial begin
      // Reset, then the first instruction 1A35 fetched in the first FETCH cycle.
      apply(1, 0, 0, 16'h0, 0, 0, 16'h0);
      apply(1, 0, 1, 16'h0, 1, 1, 16'h1234);
      apply(0, 1, 1, 16'h1A35, 0, 0, 16'h0);
      apply(0, 1, 1, 16'h1A35, 0, 0, 16'h0);
      // pc_load in DECODE and in EXECUTE without exec_done must be ignored.
      apply(0, 1, 1, 16'hBEEF, 0, 1, 16'h5555);
      apply(0, 1, 1, 16'hBEEF, 0, 1, 16'h5555);
      apply(0, 1, 0, 16'h0, 1, 0, 16'h5555);
      // en low parks FETCH with no request even though ack is high.
      for (int i = 0; i < 5; i++) apply(0, 0, 1, 16'hF00D, 0, 0, 16'h0);
      apply(0, 1, 1, 16'hC7E2, 0, 0, 16'h0);
      apply(0, 1, 0, 16'h0, 0, 0, 16'h0);
      apply(0, 1, 0, 16'h0, 1, 1, 16'h0040);
      apply(0, 1, 0, 16'h0, 0, 0, 16'h0);
      // Reset while FETCH waits, then a late ack absorbed by IDLE.
      apply(1, 1, 1, 16'h9999, 0, 0, 16'h0);
      apply(0, 1, 1, 16'h8888, 0, 0, 16'h0);
      apply(0, 1, 0, 16'h0, 0, 0, 16'h0);
      apply(0, 1, 1, 16'h2E61, 0, 0, 16'h0);
      apply(0, 1, 0, 16'h0, 0, 0, 16'h0);
      apply(0, 1, 0, 16'h0, 1, 1, 16'hFFFE);
      // Randomized traffic, with branch targets biased near the wrap point.
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] t;
         t = ($urandom_range(3) == 0) ? (16'hFFFE + 16'($urandom_range(1))) : 16'($urandom);
         apply($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
               16'($urandom), $urandom_range(2) == 0, $urandom_range(1) == 1, t);
      end
      for (int i = 0; i < 4; i++) apply(0, 0, 0, 16'h0, 1, 0, 16'h0);
      chk("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
